// File: rtl/sipo_frame_ctrl.sv
// Serial framing controller: hunts a start bit, shifts WIDTH data bits MSB-first,
// checks the stop bit and presents the word through a valid/ready holding register.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    STOP    = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] sr_r, sr_s;
  logic [WIDTH-1:0] po_r, po_s;
  logic             po_valid_r, po_valid_s;
  logic             frame_err_r, frame_err_s;
  logic             overrun_r, overrun_s;
  logic             load_s;
  logic             consume_s;

  // Next-state, datapath and handshake decisions
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    sr_s        = sr_r;
    po_s        = po_r;
    frame_err_s = 1'b0;
    overrun_s   = overrun_r;
    load_s      = 1'b0;
    consume_s   = po_valid_r & po_ready;

    case (state_r)
      IDLE: begin
        if (!si) begin
          cnt_s   = {CW{1'b0}};
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sr_s = {sr_r[WIDTH-2:0], si};
        // Counter parks at WIDTH on the last shift rather than wrapping
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_FULL;
          state_s = STOP;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = SHIFT;
        end
      end
      STOP: begin
        if (si) begin
          if (!po_valid_r || po_ready) begin
            load_s = 1'b1;
            po_s   = sr_r;
          end else begin
            overrun_s = 1'b1;
          end
          state_s = IDLE;
        end else begin
          frame_err_s = 1'b1;
          state_s     = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (si) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HI;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // A load on the consume edge keeps valid high with the new word
    if (load_s) begin
      po_valid_s = 1'b1;
    end else if (consume_s) begin
      po_valid_s = 1'b0;
    end else begin
      po_valid_s = po_valid_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      sr_r        <= {WIDTH{1'b0}};
      po_r        <= {WIDTH{1'b0}};
      po_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sr_r        <= sr_s;
      po_r        <= po_s;
      po_valid_r  <= po_valid_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  assign po        = po_r;
  assign po_valid  = po_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed frame scenarios plus random
// line traffic, all compared against a bit-queue reference model.
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         si;
  logic [W-1:0] po;
  logic         po_valid;
  logic         po_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int n_pass;
  int n_total;

  // Reference model: 0 hunting, 1 collecting data, 2 expecting stop, 3 waiting for line high
  int           m_mode;
  bit           m_bits[$];
  logic [W-1:0] m_po;
  logic         m_valid;
  logic         m_ferr;
  logic         m_ovr;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .si        (si),
    .po        (po),
    .po_valid  (po_valid),
    .po_ready  (po_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic m_reset();
    m_mode  = 0;
    m_bits.delete();
    m_po    = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  function automatic logic [W-1:0] word_of_bits();
    int acc;
    acc = 0;
    foreach (m_bits[i]) acc = acc * 2 + int'(m_bits[i]);
    return W'(acc);
  endfunction

  task automatic m_edge(input bit s, input bit r);
    bit consume;
    bit loaded;
    consume = m_valid && r;
    loaded  = 1'b0;
    m_ferr  = 1'b0;
    case (m_mode)
      0: if (!s) begin m_bits.delete(); m_mode = 1; end
      1: begin
        m_bits.push_back(s);
        if (m_bits.size() == W) m_mode = 2;
      end
      2: begin
        if (s) begin
          if (!m_valid || r) begin
            m_po   = word_of_bits();
            loaded = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          m_mode = 0;
        end else begin
          m_ferr = 1'b1;
          m_mode = 3;
        end
      end
      default: if (s) m_mode = 0;
    endcase
    if (loaded) m_valid = 1'b1;
    else if (consume) m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".po"}, 32'(po), 32'(m_po));
    chk({tag, ".po_valid"}, 32'(po_valid), 32'(m_valid));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".busy"}, 32'(busy), (m_mode != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input bit s, input bit r, input string tag);
    si       = s;
    po_ready = r;
    @(posedge clk);
    m_edge(s, r);
    #1;
    check_all(tag);
  endtask

  task automatic send(input bit b[], input bit r, input string tag);
    foreach (b[i]) step(b[i], r, tag);
  endtask

  // Asynchronous reset pulse between clock edges, with si toggling meanwhile
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    si    = ~si;
    #1;
    m_reset();
    chk({tag, ".async_po"}, 32'(po), 32'd0);
    chk({tag, ".async_valid"}, 32'(po_valid), 32'd0);
    chk({tag, ".async_ovr"}, 32'(overrun), 32'd0);
    chk({tag, ".async_busy"}, 32'(busy), 32'd0);
    chk({tag, ".async_ferr"}, 32'(frame_err), 32'd0);
    @(posedge clk);
    si = ~si;
    #1;
    check_all({tag, ".held"});
    reset = 1'b1;
    si    = 1'b1;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b0;
    si       = 1'b1;
    po_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b0, "idle");

    // Reset values: load a word, then reset mid-run
    send('{0, 1, 1, 0, 1, 1}, 1'b0, "pre_rst");
    chk("pre_rst_valid", 32'(po_valid), 32'd1);
    step(1'b0, 1'b0, "pre_rst2");
    async_reset("rst1");
    repeat (3) step(1'b1, 1'b0, "post_rst");
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single frame
    send('{0, 1, 0, 1, 1, 1}, 1'b0, "single");
    chk("single_po", 32'(po), 32'h0000000b);
    chk("single_valid", 32'(po_valid), 32'd1);
    repeat (2) step(1'b1, 1'b0, "single_hold");
    chk("single_hold_po", 32'(po), 32'h0000000b);
    step(1'b1, 1'b1, "single_cons");
    chk("single_cons_valid", 32'(po_valid), 32'd0);

    // Framing error with line held low
    send('{0, 1, 1, 0, 0}, 1'b0, "ferr");
    step(1'b0, 1'b0, "ferr_stop");
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_valid", 32'(po_valid), 32'd0);
    step(1'b0, 1'b0, "ferr_low");
    chk("ferr_once", 32'(frame_err), 32'd0);
    chk("ferr_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b0, "ferr_low2");
    step(1'b1, 1'b0, "ferr_hi");
    chk("ferr_idle", 32'(busy), 32'd0);

    // Overrun: back-to-back good frames without ready
    send('{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1}, 1'b0, "ovr");
    chk("ovr_po", 32'(po), 32'h0000000f);
    chk("ovr_flag", 32'(overrun), 32'd1);
    repeat (3) step(1'b1, 1'b1, "ovr_sticky");
    chk("ovr_sticky", 32'(overrun), 32'd1);
    async_reset("rst2");

    // Simultaneous consume and load on the second stop edge
    send('{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1}, 1'b0, "sim");
    step(1'b1, 1'b1, "sim_stop");
    chk("sim_po", 32'(po), 32'h00000001);
    chk("sim_valid", 32'(po_valid), 32'd1);
    chk("sim_ovr", 32'(overrun), 32'd0);
    step(1'b1, 1'b1, "sim_drain");

    // Reset mid-frame after two data bits
    send('{0, 1, 0}, 1'b0, "midf");
    async_reset("rst3");
    repeat (2) step(1'b1, 1'b0, "midf_idle");
    chk("midf_valid", 32'(po_valid), 32'd0);
    chk("midf_ferr", 32'(frame_err), 32'd0);
    send('{0, 0, 1, 1, 0, 1}, 1'b0, "midf_next");
    chk("midf_po", 32'(po), 32'h00000006);

    // Random line traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), "rand");
      if (i == 1000) async_reset("rst_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
